// File: rtl/fw_wishbone_sram_byte_en.sv
// Wishbone target backed by byte-lane SRAM, with configurable read latency,
// write wait states and out-of-range error or silent-ack behaviour.
module fw_wishbone_sram_byte_en #(
  parameter int ADR_WIDTH    = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int MEM_BITS     = 14,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_WAIT   = 0,
  parameter bit ERR_EN       = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADR_WIDTH-1:0]   t_adr,
  input  logic [DAT_WIDTH-1:0]   t_dat_w,
  output logic [DAT_WIDTH-1:0]   t_dat_r,
  input  logic                   t_cyc,
  input  logic                   t_stb,
  input  logic                   t_we,
  input  logic [DAT_WIDTH/8-1:0] t_sel,
  output logic                   t_ack,
  output logic                   t_err
);
  localparam int NB    = DAT_WIDTH / 8;
  localparam int ALIGN = $clog2(NB);
  localparam int DEPTH = 2 ** MEM_BITS;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 oor_q, oor_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DAT_WIDTH-1:0] datR_q, datR_d;
  logic [DAT_WIDTH-1:0] rdSnap_q, rdSnap_d;

  logic                 accept;
  logic                 reqOor;
  logic                 wrCommit;
  logic [MEM_BITS-1:0]  reqIdx;
  logic [DAT_WIDTH-1:0] memRd;

  assign accept   = (state_q == IDLE) && t_cyc && t_stb;
  assign reqOor   = (t_adr >> (MEM_BITS + ALIGN)) != '0;
  assign reqIdx   = t_adr[MEM_BITS+ALIGN-1:ALIGN];
  assign wrCommit = accept && t_we && !reqOor && !reset;

  // Lanes commit at the accept edge, so any later read snapshot sees the new data.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
      if (wrCommit && t_sel[i]) mem_q[reqIdx] <= t_dat_w[8*i +: 8];
    end

    assign memRd[8*i +: 8] = mem_q[reqIdx];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oor_d    = oor_q;
    rdSnap_d = rdSnap_q;
    datR_d   = datR_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          oor_d = reqOor;
          if (t_we) begin
            if (WRITE_WAIT == 0) begin
              state_d = RESP;
            end else begin
              state_d = WR;
              cnt_d   = 3'(WRITE_WAIT - 1);
            end
          end else begin
            rdSnap_d = reqOor ? '0 : memRd;
            if (READ_LATENCY == 1) begin
              state_d = RESP;
              datR_d  = reqOor ? '0 : memRd;
            end else begin
              state_d = RD;
              cnt_d   = 3'(READ_LATENCY - 2);
            end
          end
        end
      end
      RD: begin
        if (!t_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          datR_d  = rdSnap_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WR: begin
        if (!t_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Terminations are registered copies of "next cycle is RESP".
    ack_d = (state_d == RESP) && !(oor_d && ERR_EN);
    err_d = (state_d == RESP) && oor_d && ERR_EN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      oor_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      datR_q   <= '0;
      rdSnap_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oor_q    <= oor_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      datR_q   <= datR_d;
      rdSnap_q <= rdSnap_d;
    end
  end

  assign t_ack   = ack_q;
  assign t_err   = err_q;
  assign t_dat_r = datR_q;

endmodule

// File: tb/tb_fw_wishbone_sram_byte_en.sv
// Bench for fw_wishbone_sram_byte_en: five configurations share one bus, each
// selected by its own t_cyc, checked every cycle against a byte-level model.
module tb_fw_wishbone_sram_byte_en;
  localparam int NI = 5;

  logic          clock;
  logic          reset;
  logic [31:0]   adr;
  logic [63:0]   datW;
  logic [7:0]    sel;
  logic          we;
  logic          stb;
  logic [NI-1:0] cycV;
  logic [NI-1:0] ackV;
  logic [NI-1:0] errV;
  logic [31:0]   datR0, datR1, datR2;
  logic [63:0]   datR3;
  logic [7:0]    datR4;
  logic [63:0]   datRV [NI];

  assign datRV[0] = {32'b0, datR0};
  assign datRV[1] = {32'b0, datR1};
  assign datRV[2] = {32'b0, datR2};
  assign datRV[3] = datR3;
  assign datRV[4] = {56'b0, datR4};

  // u0: defaults; u1: slow read/write; u2: no error reporting, RL=3; u3: 64-bit; u4: 8-bit
  fw_wishbone_sram_byte_en #(.ADR_WIDTH(32), .DAT_WIDTH(32), .MEM_BITS(14),
    .READ_LATENCY(1), .WRITE_WAIT(0), .ERR_EN(1'b1)) u0 (
    .clock(clock), .reset(reset), .t_adr(adr), .t_dat_w(datW[31:0]), .t_dat_r(datR0),
    .t_cyc(cycV[0]), .t_stb(stb), .t_we(we), .t_sel(sel[3:0]), .t_ack(ackV[0]), .t_err(errV[0]));
  fw_wishbone_sram_byte_en #(.ADR_WIDTH(32), .DAT_WIDTH(32), .MEM_BITS(14),
    .READ_LATENCY(4), .WRITE_WAIT(3), .ERR_EN(1'b1)) u1 (
    .clock(clock), .reset(reset), .t_adr(adr), .t_dat_w(datW[31:0]), .t_dat_r(datR1),
    .t_cyc(cycV[1]), .t_stb(stb), .t_we(we), .t_sel(sel[3:0]), .t_ack(ackV[1]), .t_err(errV[1]));
  fw_wishbone_sram_byte_en #(.ADR_WIDTH(32), .DAT_WIDTH(32), .MEM_BITS(14),
    .READ_LATENCY(3), .WRITE_WAIT(0), .ERR_EN(1'b0)) u2 (
    .clock(clock), .reset(reset), .t_adr(adr), .t_dat_w(datW[31:0]), .t_dat_r(datR2),
    .t_cyc(cycV[2]), .t_stb(stb), .t_we(we), .t_sel(sel[3:0]), .t_ack(ackV[2]), .t_err(errV[2]));
  fw_wishbone_sram_byte_en #(.ADR_WIDTH(32), .DAT_WIDTH(64), .MEM_BITS(14),
    .READ_LATENCY(1), .WRITE_WAIT(0), .ERR_EN(1'b1)) u3 (
    .clock(clock), .reset(reset), .t_adr(adr), .t_dat_w(datW), .t_dat_r(datR3),
    .t_cyc(cycV[3]), .t_stb(stb), .t_we(we), .t_sel(sel), .t_ack(ackV[3]), .t_err(errV[3]));
  fw_wishbone_sram_byte_en #(.ADR_WIDTH(32), .DAT_WIDTH(8), .MEM_BITS(14),
    .READ_LATENCY(1), .WRITE_WAIT(0), .ERR_EN(1'b1)) u4 (
    .clock(clock), .reset(reset), .t_adr(adr), .t_dat_w(datW[7:0]), .t_dat_r(datR4),
    .t_cyc(cycV[4]), .t_stb(stb), .t_we(we), .t_sel(sel[0:0]), .t_ack(ackV[4]), .t_err(errV[4]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycleNo = 0;
  always @(posedge clock) cycleNo <= cycleNo + 1;

  int nCompared = 0;
  int nMismatched = 0;

  // Per-instance configuration as the bench understands it
  function automatic int rlOf(input int k);
    case (k)
      1: return 4;
      2: return 3;
      default: return 1;
    endcase
  endfunction
  function automatic int wwOf(input int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic bit errEnOf(input int k);
    return k != 2;
  endfunction
  function automatic int nbOf(input int k);
    case (k)
      3: return 8;
      4: return 1;
      default: return 4;
    endcase
  endfunction
  function automatic int alignOf(input int k);
    case (k)
      3: return 3;
      4: return 0;
      default: return 2;
    endcase
  endfunction

  // Byte-addressed memory model: key = instance, word, lane
  logic [7:0] mdlMem [int];

  function automatic bit isOor(input int k, input logic [31:0] a);
    return (a >> (14 + alignOf(k))) != 32'h0;
  endfunction
  function automatic int wordOf(input int k, input logic [31:0] a);
    return int'((a >> alignOf(k)) & 32'h3FFF);
  endfunction
  function automatic int keyOf(input int k, input int w, input int l);
    return k * (1 << 20) + w * nbOf(k) + l;
  endfunction
  function automatic void modelWrite(input int k, input logic [31:0] a, input logic [63:0] d,
                                     input logic [7:0] s);
    for (int l = 0; l < nbOf(k); l++)
      if (s[l]) mdlMem[keyOf(k, wordOf(k, a), l)] = d[8*l +: 8];
  endfunction
  function automatic logic [63:0] modelRead(input int k, input logic [31:0] a);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < nbOf(k); l++)
      if (mdlMem.exists(keyOf(k, wordOf(k, a), l))) r[8*l +: 8] = mdlMem[keyOf(k, wordOf(k, a), l)];
    return r;
  endfunction

  typedef struct {
    int          inst;
    int          cyc;
    bit          isErr;
    bit          isRd;
    logic [63:0] data;
  } exp_t;
  exp_t sched[$];

  int          termCyc  [NI];
  bit          termErr  [NI];
  logic [63:0] termData [NI];

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cycleNo);
    end
  endtask

  // Every cycle, each instance's ack/err must match the model's schedule exactly
  always @(negedge clock) begin
    for (int k = 0; k < NI; k++) begin
      bit          eA, eE, eRd;
      logic [63:0] eD;
      eA = 1'b0; eE = 1'b0; eRd = 1'b0; eD = '0;
      for (int j = 0; j < sched.size(); j++) begin
        if (sched[j].inst == k && sched[j].cyc == cycleNo) begin
          eE  = sched[j].isErr;
          eA  = !sched[j].isErr;
          eRd = sched[j].isRd && !sched[j].isErr;
          eD  = sched[j].data;
          sched.delete(j);
          break;
        end
      end
      checkOutput($sformatf("ack[u%0d]", k), 64'(ackV[k]), 64'(eA));
      checkOutput($sformatf("err[u%0d]", k), 64'(errV[k]), 64'(eE));
      if (eRd) checkOutput($sformatf("rdata[u%0d]", k), datRV[k], eD);
      if (ackV[k] || errV[k]) begin
        termCyc[k]  = cycleNo;
        termErr[k]  = errV[k];
        termData[k] = datRV[k];
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request on instance k, schedule its termination, and return in the
  // first cycle after RESP. keep leaves cyc/stb high for a back-to-back request.
  task automatic applyStimulus(input int k, input bit w, input logic [31:0] a,
                               input logic [63:0] d, input logic [7:0] s,
                               input bit keep, output int acc);
    exp_t e;
    acc  = cycleNo;
    adr  = a; datW = d; sel = s; we = w; stb = 1'b1;
    cycV = NI'(1 << k);
    e.inst  = k;
    e.isRd  = !w;
    e.isErr = isOor(k, a) && errEnOf(k);
    e.data  = (!w && !isOor(k, a)) ? modelRead(k, a) : 64'h0;
    e.cyc   = acc + (w ? 1 + wwOf(k) : rlOf(k));
    if (w && !isOor(k, a)) modelWrite(k, a, d, s);
    sched.push_back(e);
    repeat (e.cyc - acc) step();
    if (!keep) begin
      stb  = 1'b0;
      cycV = '0;
    end
    step();
  endtask

  task automatic checkTerm(input string nm, input int k, input int acc, input int lat, input bit isErr);
    checkOutput({nm, " latency"}, 64'(termCyc[k] - acc), 64'(lat));
    checkOutput({nm, " err"}, 64'(termErr[k]), 64'(isErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int first;
    reset = 1'b1; cycV = '0; stb = 1'b0; we = 1'b0; adr = '0; datW = '0; sel = '0;
    for (int k = 0; k < NI; k++) begin
      termCyc[k] = -100; termErr[k] = 1'b0; termData[k] = '0;
    end
    repeat (3) step();
    checkOutput("reset ack", 64'(ackV), 64'h0);
    checkOutput("reset err", 64'(errV), 64'h0);
    checkOutput("reset dat_r u0", datRV[0], 64'h0);
    checkOutput("reset dat_r u3", datRV[3], 64'h0);
    reset = 1'b0;
    step();

    // Default configuration: single-cycle write and read
    applyStimulus(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, 1'b0, acc);
    checkTerm("u0 write", 0, acc, 1, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 64'h0, 8'hF, 1'b0, acc);
    checkTerm("u0 read", 0, acc, 1, 1'b0);
    checkOutput("u0 read data", termData[0], 64'hDEADBEEF);

    // Byte enables over a preloaded word
    u0.g_lane[0].mem_q[8] <= 8'h44;
    u0.g_lane[1].mem_q[8] <= 8'h33;
    u0.g_lane[2].mem_q[8] <= 8'h22;
    u0.g_lane[3].mem_q[8] <= 8'h11;
    modelWrite(0, 32'h20, 64'h11223344, 8'hF);
    #1;
    applyStimulus(0, 1'b1, 32'h20, 64'hAABBCCDD, 8'h5, 1'b0, acc);
    applyStimulus(0, 1'b0, 32'h20, 64'h0, 8'hF, 1'b0, acc);
    checkOutput("u0 sel=0101 data", termData[0], 64'h11BB33DD);
    applyStimulus(0, 1'b1, 32'h20, 64'hFFFFFFFF, 8'h0, 1'b0, acc);
    checkTerm("u0 sel=0 write", 0, acc, 1, 1'b0);
    applyStimulus(0, 1'b0, 32'h22, 64'h0, 8'hF, 1'b0, acc);
    checkOutput("u0 sel=0 data", termData[0], 64'h11BB33DD);

    // Out-of-range with error reporting; the write must not alias word 4
    applyStimulus(0, 1'b1, 32'h0001_0010, 64'h12345678, 8'hF, 1'b0, acc);
    checkTerm("u0 oor write", 0, acc, 1, 1'b1);
    applyStimulus(0, 1'b0, 32'h0001_0000, 64'h0, 8'hF, 1'b0, acc);
    checkTerm("u0 oor read", 0, acc, 1, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 64'h0, 8'hF, 1'b0, acc);
    checkOutput("u0 no alias", termData[0], 64'hDEADBEEF);

    // Latency and wait states, then back-to-back reads
    applyStimulus(1, 1'b1, 32'h40, 64'hCAFEF00D, 8'hF, 1'b0, acc);
    checkTerm("u1 write", 1, acc, 4, 1'b0);
    applyStimulus(1, 1'b0, 32'h40, 64'h0, 8'hF, 1'b0, acc);
    checkTerm("u1 read", 1, acc, 4, 1'b0);
    applyStimulus(1, 1'b0, 32'h40, 64'h0, 8'hF, 1'b1, first);
    checkOutput("u1 b2b #1", 64'(termCyc[1] - first), 64'd4);
    applyStimulus(1, 1'b0, 32'h40, 64'h0, 8'hF, 1'b1, acc);
    checkOutput("u1 b2b #2", 64'(termCyc[1] - first), 64'd9);
    applyStimulus(1, 1'b0, 32'h40, 64'h0, 8'hF, 1'b0, acc);
    checkOutput("u1 b2b #3", 64'(termCyc[1] - first), 64'd14);
    checkOutput("u1 b2b data", termData[1], 64'hCAFEF00D);

    // Out-of-range without error reporting
    applyStimulus(2, 1'b1, 32'h0, 64'h01020304, 8'hF, 1'b0, acc);
    applyStimulus(2, 1'b1, 32'h0001_0000, 64'hFFFFFFFF, 8'hF, 1'b0, acc);
    checkTerm("u2 oor write", 2, acc, 1, 1'b0);
    applyStimulus(2, 1'b0, 32'h0, 64'h0, 8'hF, 1'b0, acc);
    checkTerm("u2 read", 2, acc, 3, 1'b0);
    checkOutput("u2 no alias", termData[2], 64'h01020304);
    applyStimulus(2, 1'b0, 32'h0001_0000, 64'h0, 8'hF, 1'b0, acc);
    checkTerm("u2 oor read", 2, acc, 3, 1'b0);
    checkOutput("u2 oor data", termData[2], 64'h0);

    // Abort a read in cycle 1; a new read is accepted in cycle 2
    adr = 32'h0; we = 1'b0; sel = 8'hF; stb = 1'b1; cycV = NI'(1 << 2);
    acc = cycleNo;
    step();
    stb = 1'b0; cycV = '0;
    step();
    applyStimulus(2, 1'b0, 32'h0, 64'h0, 8'hF, 1'b0, first);
    checkOutput("u2 abort accept", 64'(first - acc), 64'd2);
    checkTerm("u2 after abort", 2, first, 3, 1'b0);
    checkOutput("u2 after abort data", termData[2], 64'h01020304);

    // Reset in cycle 1 of a slow write: no termination, write stays committed
    adr = 32'h80; datW = 64'h55AA55AA; sel = 8'hF; we = 1'b1; stb = 1'b1; cycV = NI'(1 << 1);
    modelWrite(1, 32'h80, 64'h55AA55AA, 8'hF);
    step();
    reset = 1'b1; stb = 1'b0; cycV = '0;
    step();
    reset = 1'b0;
    checkOutput("u1 dat_r after reset", datRV[1], 64'h0);
    checkOutput("u0 dat_r after reset", datRV[0], 64'h0);
    step();
    applyStimulus(1, 1'b0, 32'h80, 64'h0, 8'hF, 1'b0, acc);
    checkOutput("u1 write survives reset", termData[1], 64'h55AA55AA);

    // 64-bit lanes: 0x8 and 0xF both address word 1
    applyStimulus(3, 1'b1, 32'h8, 64'h1122334455667788, 8'hFF, 1'b0, acc);
    checkOutput("u3 word1 lane0", 64'(u3.g_lane[0].mem_q[1]), 64'h88);
    applyStimulus(3, 1'b0, 32'hF, 64'h0, 8'hFF, 1'b0, acc);
    checkOutput("u3 read 0xF", termData[3], 64'h1122334455667788);
    applyStimulus(3, 1'b1, 32'h8, 64'hAAAAAAAAAAAAAAAA, 8'h81, 1'b0, acc);
    applyStimulus(3, 1'b0, 32'h8, 64'h0, 8'hFF, 1'b0, acc);
    checkOutput("u3 sel=0x81 data", termData[3], 64'hAA223344556677AA);

    // 8-bit lanes: 0x1 is word 1, no low bits ignored
    applyStimulus(4, 1'b1, 32'h1, 64'h5A, 8'h1, 1'b0, acc);
    checkOutput("u4 word1", 64'(u4.g_lane[0].mem_q[1]), 64'h5A);
    applyStimulus(4, 1'b1, 32'h2, 64'hC3, 8'h1, 1'b0, acc);
    applyStimulus(4, 1'b0, 32'h1, 64'h0, 8'h1, 1'b0, acc);
    checkOutput("u4 read 0x1", termData[4], 64'h5A);
    applyStimulus(4, 1'b0, 32'h4000, 64'h0, 8'h1, 1'b0, acc);
    checkTerm("u4 oor read", 4, acc, 1, 1'b1);

    repeat (3) step();
    checkOutput("pending terminations", 64'(sched.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
